// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : imem_arbiter
//  Description : Two-requester (fetch / load) arbiter in front of a shared
//                byte-wide combinational ROM. Each grant reads four
//                consecutive bytes, assembles a big-endian 32-bit word and
//                returns it with a one-cycle valid pulse. Ties are resolved
//                round-robin. Defining IMEM_ARB_FIXED_PRIO_EN switches to
//                fixed priority, where fetch always wins a tie.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_arbiter #(
   parameter int A_WIDTH = 32,
   parameter int D_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               if_req,
   input  logic [A_WIDTH-1:0] if_addr,
   output logic               if_valid,
   output logic [31:0]        if_data,
   input  logic               ld_req,
   input  logic [A_WIDTH-1:0] ld_addr,
   output logic               ld_valid,
   output logic [31:0]        ld_data,
   output logic [A_WIDTH-1:0] mem_addr,
   input  logic [D_WIDTH-1:0] mem_rdata,
   output logic               busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_READ = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]         state_q;
   logic [1:0]         state_d;
   logic               sel_ld_d;   // arbitration result this cycle (1 = load)
   logic               sel_ld_q;   // owner of the transaction in flight
   logic [A_WIDTH-1:0] base_q;
   logic [1:0]         cnt_q;
   logic [31:0]        word_q;     // assembly buffer for the word being read
   logic               if_valid_q;
   logic               ld_valid_q;
   logic [31:0]        if_data_q;
   logic [31:0]        ld_data_q;
`ifndef IMEM_ARB_FIXED_PRIO_EN
   logic               last_ld_q;  // 1 = load won the previous transaction
`endif

   // Pick the winner among the current requests.
   always_comb begin
`ifdef IMEM_ARB_FIXED_PRIO_EN
      sel_ld_d = ~if_req;
`else
      if (if_req && ld_req) begin
         sel_ld_d = ~last_ld_q;
      end else begin
         sel_ld_d = ~if_req;
      end
`endif
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: four read cycles, then one response cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (if_req || ld_req) begin
               state_d = S_READ;
            end
         end
         S_READ: begin
            if (cnt_q == 2'd3) begin
               state_d = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State-decoded outputs: ROM address only while reading, zero otherwise.
   always_comb begin
      busy     = (state_q != S_IDLE);
      mem_addr = '0;
      if (state_q == S_READ) begin
         mem_addr = base_q + {{(A_WIDTH-2){1'b0}}, cnt_q};
      end
   end

   // Datapath: latch grant, gather bytes, deliver the word on leaving RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_ld_q   <= 1'b0;
         base_q     <= '0;
         cnt_q      <= 2'd0;
         word_q     <= 32'd0;
         if_valid_q <= 1'b0;
         ld_valid_q <= 1'b0;
         if_data_q  <= 32'd0;
         ld_data_q  <= 32'd0;
`ifndef IMEM_ARB_FIXED_PRIO_EN
         last_ld_q  <= 1'b1;
`endif
      end else begin
         if_valid_q <= 1'b0;
         ld_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (if_req || ld_req) begin
                  sel_ld_q <= sel_ld_d;
                  base_q   <= sel_ld_d ? ld_addr : if_addr;
                  cnt_q    <= 2'd0;
               end
            end
            S_READ: begin
               // Lowest address lands in the most significant byte.
               case (cnt_q)
                  2'd0:    word_q[31:24] <= mem_rdata;
                  2'd1:    word_q[23:16] <= mem_rdata;
                  2'd2:    word_q[15:8]  <= mem_rdata;
                  default: word_q[7:0]   <= mem_rdata;
               endcase
               cnt_q <= cnt_q + 2'd1;
            end
            S_RESP: begin
               if (sel_ld_q) begin
                  ld_valid_q <= 1'b1;
                  ld_data_q  <= word_q;
               end else begin
                  if_valid_q <= 1'b1;
                  if_data_q  <= word_q;
               end
`ifndef IMEM_ARB_FIXED_PRIO_EN
               last_ld_q <= sel_ld_q;
`endif
            end
            default: begin
               cnt_q <= 2'd0;
            end
         endcase
      end
   end

   assign if_valid = if_valid_q;
   assign ld_valid = ld_valid_q;
   assign if_data  = if_data_q;
   assign ld_data  = ld_data_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_arbiter
//  Description : Self-checking bench for imem_arbiter with a ROM model and a
//                scoreboard of expected deliveries (requester, word, cycle).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_valid;
   logic [31:0] if_data;
   logic        ld_req;
   logic [31:0] ld_addr;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic [31:0] mem_addr;
   logic [7:0]  mem_rdata;
   logic        busy;

   int cyc = 0;
   int n_vec = 0;
   int n_bad = 0;
   logic [31:0] last_if = 32'd0;
   logic [31:0] last_ld = 32'd0;

   typedef struct {
      bit          is_ld;
      logic [31:0] data;
      int          cyc;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      bit          ie;
      logic [31:0] ia;
      bit          le;
      logic [31:0] la;
      bit          first_ld;
   } vec_t;
   vec_t vt[8];

   imem_arbiter #(.A_WIDTH(32), .D_WIDTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_valid (if_valid),
      .if_data  (if_data),
      .ld_req   (ld_req),
      .ld_addr  (ld_addr),
      .ld_valid (ld_valid),
      .ld_data  (ld_data),
      .mem_addr (mem_addr),
      .mem_rdata(mem_rdata),
      .busy     (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] rom(input logic [31:0] a);
      case (a)
         32'd0:   rom = 8'h13;
         32'd1:   rom = 8'h00;
         32'd2:   rom = 8'h50;
         32'd3:   rom = 8'h00;
         default: rom = a[7:0] ^ a[31:24] ^ 8'h3C;
      endcase
   endfunction

   function automatic logic [31:0] word_at(input logic [31:0] a);
      word_at = {rom(a), rom(a + 32'd1), rom(a + 32'd2), rom(a + 32'd3)};
   endfunction

   assign mem_rdata = rom(mem_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Compare any valid pulse on this negedge against the scoreboard head.
   task automatic monitor(inout bit rereq);
      exp_t e;
      if (if_valid && ld_valid) chk("both_valid", 32'd1, 32'd0);
      if (if_valid || ld_valid) begin
         if (sbq.size() == 0) begin
            chk("spurious_valid", {30'd0, if_valid, ld_valid}, 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("winner", {31'd0, ld_valid}, {31'd0, e.is_ld});
            chk("data", ld_valid ? ld_data : if_data, e.data);
            chk("latency", cyc, e.cyc);
            if (e.is_ld) last_ld = e.data;
            else         last_if = e.data;
         end
         if (ld_valid) ld_req = 1'b0;
         if (if_valid) begin
            if (rereq) begin
               if_addr = 32'h8;
               rereq   = 1'b0;
            end else begin
               if_req = 1'b0;
            end
         end
      end
   endtask

   // Drive one request pattern and wait until every expected word arrives.
   task automatic run_txn(input bit ie, input logic [31:0] ia, input bit le,
                          input logic [31:0] la, input bit first_ld,
                          input bit chg, input bit rereq_in);
      int c0;
      bit fl;
      bit rereq;
      logic [31:0] base;
      exp_t e;
      fl    = first_ld;
      rereq = rereq_in;
`ifdef IMEM_ARB_FIXED_PRIO_EN
      if (ie && le) fl = 1'b0;
`endif
      @(negedge clk);
      if_req = ie; if_addr = ia; ld_req = le; ld_addr = la;
      c0 = cyc;
      base = fl ? la : ia;
      if (ie && le) begin
         e = '{fl, fl ? word_at(la) : word_at(ia), c0 + 6};
         sbq.push_back(e);
         if (rereq) begin
`ifdef IMEM_ARB_FIXED_PRIO_EN
            e = '{1'b0, word_at(32'h8), c0 + 12}; sbq.push_back(e);
            e = '{1'b1, word_at(la), c0 + 18};    sbq.push_back(e);
`else
            e = '{1'b1, word_at(la), c0 + 12};    sbq.push_back(e);
            e = '{1'b0, word_at(32'h8), c0 + 18}; sbq.push_back(e);
`endif
         end else begin
            e = '{!fl, fl ? word_at(ia) : word_at(la), c0 + 12};
            sbq.push_back(e);
         end
      end else begin
         e = '{le, le ? word_at(la) : word_at(ia), c0 + 6};
         sbq.push_back(e);
      end
      for (int i = 1; i <= 40 && sbq.size() > 0; i++) begin
         @(negedge clk);
         if (i == 1) chk("busy", {31'd0, busy}, 32'd1);
         if (i >= 1 && i <= 4) chk("mem_addr", mem_addr, base + 32'(i - 1));
         if (i == 5 || i == 6) chk("mem_addr_idle", mem_addr, 32'd0);
         if (i == 2 && chg) if_addr = 32'h8;
         monitor(rereq);
      end
      if (sbq.size() > 0) begin
         n_vec++; n_bad++;
         $display("FAIL timeout: %0d deliveries missing, expected 0", sbq.size());
         sbq.delete();
      end
      chk("hold_if", if_data, last_if);
      chk("hold_ld", ld_data, last_ld);
   endtask

   initial begin
      bit dummy;
      int c0;
      vt[0] = '{1'b0, 32'h0,        1'b1, 32'h100,      1'b1};
      vt[1] = '{1'b1, 32'h10,       1'b1, 32'h20,       1'b0};
      vt[2] = '{1'b1, 32'h30,       1'b1, 32'h40,       1'b0};
      vt[3] = '{1'b1, 32'h50,       1'b0, 32'h0,        1'b0};
      vt[4] = '{1'b1, 32'h60,       1'b1, 32'h70,       1'b1};
      vt[5] = '{1'b1, 32'h80,       1'b1, 32'h90,       1'b1};
      vt[6] = '{1'b0, 32'h0,        1'b1, 32'hFFFFFFFE, 1'b1};
      vt[7] = '{1'b1, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0};

      rst_n = 1'b0; if_req = 1'b0; ld_req = 1'b0; if_addr = '0; ld_addr = '0;
      #1;
      chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_ld_valid", {31'd0, ld_valid}, 32'd0);
      chk("rst_if_data", if_data, 32'd0);
      chk("rst_ld_data", ld_data, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // First tie after reset goes to fetch; fetch re-requests and the
      // following tie goes to load.
      run_txn(1'b1, 32'h0, 1'b1, 32'h4, 1'b0, 1'b0, 1'b1);

      // Reset in the middle of a read discards the transaction.
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h0;
      c0 = cyc;
      repeat (3) @(negedge clk);
      chk("rst_mid_cnt2", mem_addr, 32'd2);
      rst_n = 1'b0;
      if_req = 1'b0;
      #1;
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_mem_addr", mem_addr, 32'd0);
      chk("mid_rst_if_data", if_data, 32'd0);
      chk("mid_rst_ld_data", ld_data, 32'd0);
      chk("mid_rst_valids", {30'd0, if_valid, ld_valid}, 32'd0);
      last_if = 32'd0;
      last_ld = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("no_valid_after_rst", {30'd0, if_valid, ld_valid}, 32'd0);
      end

      // Basic fetch of ROM bytes 0..3.
      run_txn(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("word0_literal", if_data, 32'h13005000);

      // Address moved after grant must be ignored.
      run_txn(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("addr_change_literal", if_data, 32'h13005000);

      for (int v = 0; v < 8; v++) begin
         run_txn(vt[v].ie, vt[v].ia, vt[v].le, vt[v].la, vt[v].first_ld, 1'b0, 1'b0);
      end
      chk("wrap_word", ld_data, {rom(32'hFFFFFFFE), rom(32'hFFFFFFFF), 8'h13, 8'h00});

      // Idle tail: nothing further may be delivered.
      dummy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         monitor(dummy);
         chk("idle_busy", {31'd0, busy}, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter A_WIDTH, default 32, byte-address width of memory port and requester addresses.
REQ-002 SHALL have parameter D_WIDTH, default 8, memory data width; only 8 supported.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port if_req  input  1  fetch requester wants a 32-bit word.
REQ-006 SHALL have port if_addr  input  A_WIDTH  fetch byte address.
REQ-007 SHALL have port if_valid  output  1  one-cycle pulse, if_data valid.
REQ-008 SHALL have port if_data  output  32  assembled fetch word.
REQ-009 SHALL have port ld_req  input  1  load requester wants a 32-bit word.
REQ-010 SHALL have port ld_addr  input  A_WIDTH  load byte address.
REQ-011 SHALL have port ld_valid  output  1  one-cycle pulse, ld_data valid.
REQ-012 SHALL have port ld_data  output  32  assembled load word.
REQ-013 SHALL have port mem_addr  output  A_WIDTH  byte address to shared byte-wide ROM.
REQ-014 SHALL have port mem_rdata  input  D_WIDTH  ROM byte, combinational from mem_addr, same cycle.
REQ-015 SHALL have port busy  output  1  high whenever FSM not in IDLE.

Function
REQ-016 FSM SHALL have states IDLE, READ, RESP.
REQ-017 IDLE: no request -> stay; any request -> latch winner and its address into base register, cnt<=0, go READ.
REQ-018 Arbitration SHALL be round-robin: both requesting -> grant the one not granted last; after reset, fetch wins first tie.
REQ-019 READ: mem_addr SHALL equal base+cnt, computed modulo 2^A_WIDTH (wrap from all-ones to 0, no flag).
REQ-020 READ: each cycle mem_rdata SHALL be stored into byte lane cnt; byte at base is bits 31:24, base+1 bits 23:16, base+2 bits 15:8, base+3 bits 7:0.
REQ-021 READ: cnt SHALL increment 0..3; at cnt==3 go RESP.
REQ-022 RESP: winner's valid SHALL pulse exactly one cycle with winner's data; last-winner SHALL update; go IDLE.
REQ-023 Latency SHALL be fixed: request sampled in IDLE at edge N -> valid high in cycle N+5.
REQ-024 if_data/ld_data SHALL hold last delivered word until next delivery to that requester.
REQ-025 mem_addr SHALL be driven 0 in IDLE and RESP.
REQ-026 Requester SHALL hold req and addr stable until its valid; address changes after grant SHALL be ignored (base latched).
REQ-027 Request deasserted mid-transaction SHALL NOT abort; word still read, valid still pulsed.
REQ-028 Losing requester SHALL be served in next IDLE if still requesting; no request ever lost or starved.
REQ-029 Both valids SHALL never be high in the same cycle.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, cnt=0, base=0, last-winner=load (so fetch wins first tie), if_valid=0, ld_valid=0, if_data=0, ld_data=0, mem_addr=0, busy=0.
REQ-031 Reset asserted in READ or RESP SHALL discard the transaction; no valid pulse after release.
REQ-032 After rst_n rises, first request SHALL be accepted at the first rising edge.

Configuration
REQ-033 Macro IMEM_ARB_FIXED_PRIO_EN defined: fetch SHALL always win ties, last-winner register unused.
REQ-034 Macro IMEM_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-018.

Verification
REQ-035 ROM bytes 0x00..0x03 = 13,00,50,00; if_req, if_addr=0 -> if_valid in cycle 5, if_data=0x13005000.
REQ-036 if_req and ld_req together after reset, if_addr=0, ld_addr=4 -> fetch served first (cycle 5), load second (cycle 11); repeat tie -> load first.
REQ-037 Same tie with IMEM_ARB_FIXED_PRIO_EN -> fetch wins every tie; load served only when fetch idle.
REQ-038 ld_addr=0xFFFFFFFE -> mem_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001; ld_data assembled in that order.
REQ-039 rst_n pulsed low during READ cnt=2 -> all outputs 0 at once, no valid pulse, next request served normally.
REQ-040 if_addr changed to 8 two cycles after grant of addr 0 -> if_data from bytes 0..3.
